// File: rtl/output_scheduler.sv
// output_scheduler: per-output-port drain stage behind 8 input FIFOs.
// The scheduler picks a non-empty FIFO round-robin and keeps the grant for a
// whole packet, popping it word by word into a registered valid/ready stream.
// A header word carries LEN (payload words that follow) at [LEN_LSB+7:LEN_LSB].
// Optional feature: define OSCHED_TIMEOUT_EN to abort a packet whose FIFO
// stays empty for TIMEOUT consecutive cycles in BODY.
module output_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NPORTS  = 8,
  parameter int LEN_LSB = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       fifo_empty,
  input  logic [NPORTS*WIDTH-1:0] fifo_data,
  output logic [NPORTS-1:0]       fifo_pop,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_last,
  output logic                    out_abort,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  // Grant is 3 bits wide and the stall counter is 8 bits wide.
  if (NPORTS != 8) begin : g_chk_nports
    $error("output_scheduler supports exactly 8 FIFOs");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk_timeout
    $error("output_scheduler TIMEOUT must be 1..255");
  end

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [7:0]       remaining;

  logic             cur_empty;
  logic [WIDTH-1:0] cur_word;
  logic [7:0]       hdr_len;
  logic             slot_free;
  logic             xfer;
  logic             found;
  logic [2:0]       pick;
  logic [2:0]       idx;

  assign cur_empty = fifo_empty[grant_id];
  assign cur_word  = fifo_data[WIDTH*grant_id +: WIDTH];
  assign hdr_len   = cur_word[LEN_LSB +: 8];
  assign slot_free = !out_valid || out_ready;
  assign xfer      = (state != IDLE) && !cur_empty && slot_free;
  assign busy      = (state == HEAD) || (state == BODY);

  // Pop the granted FIFO on every transfer; suppressed while reset is held.
  always_comb begin
    fifo_pop = '0;
    if (reset && xfer) fifo_pop[grant_id] = 1'b1;
  end

  // Round-robin search for the first non-empty FIFO starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = rr_ptr + 3'(k);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef OSCHED_TIMEOUT_EN
  localparam logic [7:0] STALL_LIM = 8'(TIMEOUT - 1);
  logic [7:0] stall_cnt;
`else
  assign out_abort = 1'b0;
`endif

  // Packet FSM and output register; out_* only change on a transfer so they
  // stay stable while the downstream applies backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_last  <= 1'b0;
`ifdef OSCHED_TIMEOUT_EN
      out_abort <= 1'b0;
      stall_cnt <= '0;
`endif
    end else begin
`ifdef OSCHED_TIMEOUT_EN
      out_abort <= 1'b0;
`endif
      if (xfer) begin
        out_data  <= cur_word;
        out_valid <= 1'b1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            state    <= HEAD;
          end
        end
        HEAD: begin
          if (xfer) begin
            out_sop   <= 1'b1;
            remaining <= hdr_len;
            if (hdr_len == 8'd0) begin
              out_last <= 1'b1;
              state    <= IDLE;
              rr_ptr   <= grant_id + 3'd1;
            end else begin
              out_last <= 1'b0;
              state    <= BODY;
            end
          end
        end
        BODY: begin
          if (xfer) begin
            out_sop   <= 1'b0;
            remaining <= remaining - 8'd1;
`ifdef OSCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (remaining == 8'd1) begin
              out_last <= 1'b1;
              state    <= IDLE;
              rr_ptr   <= grant_id + 3'd1;
            end else begin
              out_last <= 1'b0;
            end
          end
`ifdef OSCHED_TIMEOUT_EN
          else if (cur_empty) begin
            // Starved too long: drop the rest of the packet and move on.
            if (stall_cnt == STALL_LIM) begin
              out_abort <= 1'b1;
              state     <= IDLE;
              rr_ptr    <= grant_id + 3'd1;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 8'd1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
